dbram_stream_reader: RTL and testbench

- Consumer side of the 2048x40 ping-pong (double-buffered) BRAM.
- The writer fills one bank, then posts a fill descriptor (bank, length). This block reads that bank out in address order and streams the words over a valid/ready interface.
- When the final word of the bank is accepted downstream, it pulses bank_release so the writer may refill that bank.
- It hides the 1-cycle RAM read latency with a 2-entry output buffer, so streaming runs at full rate.

---
 rtl/dbram_pkg.sv | 28 ++
 rtl/dbram_skid_fifo2.sv | 59 +++++
 rtl/dbram_stream_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_dbram_stream_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbram_pkg.sv
// Shared definitions for the double-buffered BRAM reader/writer pair.
// Holds default geometry, the reader FSM encoding, the fill descriptor
// and the output-buffer entry layout.
package dbram_pkg;

    localparam int unsigned DBRAM_AWIDTH    = 11;
    localparam int unsigned DBRAM_DWIDTH    = 40;
    localparam int unsigned DBRAM_NUM_WORDS = 2048;

    typedef enum logic {
        StIdle = 1'b0,
        StRead = 1'b1
    } rd_state_e;

    // One posted bank fill: which bank, and how many words it holds.
    typedef struct packed {
        logic                  bank;
        logic [DBRAM_AWIDTH:0] len;
    } fill_desc_t;

    // One buffered stream word with its end-of-bank tag.
    typedef struct packed {
        logic [DBRAM_DWIDTH-1:0] data;
        logic                    last;
        logic                    bank;
    } out_entry_t;

endpackage

// File: rtl/dbram_skid_fifo2.sv
// Two-entry FIFO of out_entry_t used to absorb the one-cycle RAM read latency.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write one entry (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_head         : head entry, stable until popped
//   o_valid        : FIFO non-empty
//   o_occ          : number of stored entries (0..2)
module dbram_skid_fifo2
    import dbram_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_push,
    input  out_entry_t i_data,
    input  logic       i_pop,
    output out_entry_t o_head,
    output logic       o_valid,
    output logic [1:0] o_occ
);

    out_entry_t r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_occ;
    logic       w_push;
    logic       w_pop;

    assign w_push = i_push && (r_occ != 2'd2);
    assign w_pop  = i_pop && (r_occ != 2'd0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_valid = (r_occ != 2'd0);
    assign o_occ   = r_occ;

endmodule

// File: rtl/dbram_stream_reader.sv
// Consumer side of the ping-pong BRAM: accepts fill descriptors, reads the
// filled bank in address order and streams it over valid/ready, pulsing a
// bank release once the bank's final word has been accepted.
// Ports:
//   i_clk, i_rst_n                      : clock, asynchronous active-low reset
//   i_fill_valid/o_fill_ready           : descriptor handshake
//   i_fill_bank, i_fill_len             : descriptor contents (len 1..NUM_WORDS)
//   o_ram_rd_en/_sel/_addr, i_ram_rd_data : RAM read port (data 1 cycle later)
//   o_m_valid/i_m_ready/o_m_data/o_m_last : output stream
//   o_bank_release, o_release_bank      : one-cycle drained-bank pulse
//   o_busy                              : any work pending or in flight
//   o_err                               : sticky bad-descriptor flag
module dbram_stream_reader
    import dbram_pkg::*;
#(
    parameter int unsigned AWIDTH    = DBRAM_AWIDTH,
    parameter int unsigned NUM_WORDS = DBRAM_NUM_WORDS,
    parameter int unsigned DWIDTH    = DBRAM_DWIDTH
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fill_valid,
    output logic              o_fill_ready,
    input  logic              i_fill_bank,
    input  logic [AWIDTH:0]   i_fill_len,
    output logic              o_ram_rd_en,
    output logic              o_ram_rd_sel,
    output logic [AWIDTH-1:0] o_ram_rd_addr,
    input  logic [DWIDTH-1:0] i_ram_rd_data,
    output logic              o_m_valid,
    input  logic              i_m_ready,
    output logic [DWIDTH-1:0] o_m_data,
    output logic              o_m_last,
    output logic              o_bank_release,
    output logic              o_release_bank,
    output logic              o_busy,
    output logic              o_err
);

    // Descriptor and buffer layouts come from the package.
    if (AWIDTH != DBRAM_AWIDTH || DWIDTH != DBRAM_DWIDTH) begin : g_bad_params
        $error("dbram_stream_reader: widths must match dbram_pkg");
    end

    localparam logic [AWIDTH:0] LenMax = (AWIDTH + 1)'(NUM_WORDS);
    localparam logic [AWIDTH:0] RemOne = (AWIDTH + 1)'(1);

    logic              r_alive;
    fill_desc_t        r_q [2];
    logic              r_q_wr;
    logic              r_q_rd;
    logic [1:0]        r_q_cnt;
    logic [1:0]        r_bank_busy;
    logic              r_err;
    rd_state_e         r_state;
    logic              r_bank;
    logic [AWIDTH-1:0] r_addr;
    logic [AWIDTH:0]   r_rem;
    logic              r_infl;
    logic              r_infl_last;
    logic              r_infl_bank;
    logic              r_rel;
    logic              r_rel_bank;

    rd_state_e         w_state_d;
    logic              w_bank_d;
    logic [AWIDTH-1:0] w_addr_d;
    logic [AWIDTH:0]   w_rem_d;
    logic              w_take;
    logic              w_rd_en;
    logic              w_fill_acc;
    logic              w_fill_bad;
    logic              w_fill_good;
    logic              w_q_nonempty;
    logic              w_src_valid;
    fill_desc_t        w_fill_desc;
    fill_desc_t        w_src;
    logic              w_q_push;
    logic              w_q_pop;
    logic              w_pop_out;
    logic              w_rel_d;
    logic [2:0]        w_level;
    logic              w_can_issue;
    logic [1:0]        w_occ;
    logic              w_out_valid;
    out_entry_t        w_head;
    out_entry_t        w_push_data;
    logic [1:0]        w_bank_busy_d;

    assign o_fill_ready = r_alive && (r_q_cnt != 2'd2);
    assign w_fill_acc   = i_fill_valid && o_fill_ready;
    // A bank is "in use" from acceptance until its last word is handed off.
    assign w_fill_bad   = (i_fill_len == '0) || (i_fill_len > LenMax) ||
                          r_bank_busy[i_fill_bank];
    assign w_fill_good  = w_fill_acc && !w_fill_bad;
    assign w_fill_desc  = '{bank: i_fill_bank, len: i_fill_len};

    // An empty queue is bypassed so the first read issues the cycle after accept.
    assign w_q_nonempty = (r_q_cnt != 2'd0);
    assign w_src_valid  = w_q_nonempty || w_fill_good;
    assign w_src        = w_q_nonempty ? r_q[r_q_rd] : w_fill_desc;
    assign w_q_pop      = w_take && w_q_nonempty;
    assign w_q_push     = w_fill_good && !(w_take && !w_q_nonempty);

    // Words held + word arriving - word leaving must leave room for a new read.
    assign w_pop_out   = w_out_valid && i_m_ready;
    assign w_level     = {1'b0, w_occ} + {2'b00, r_infl} - {2'b00, w_pop_out};
    assign w_can_issue = (w_level < 3'd2);
    assign w_rel_d     = w_pop_out && w_head.last;

    always_comb begin
        w_state_d = r_state;
        w_bank_d  = r_bank;
        w_addr_d  = r_addr;
        w_rem_d   = r_rem;
        w_take    = 1'b0;
        w_rd_en   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_src_valid) begin
                    w_take    = 1'b1;
                    w_state_d = StRead;
                    w_bank_d  = w_src.bank;
                    w_addr_d  = '0;
                    w_rem_d   = w_src.len;
                end
            end
            StRead: begin
                if (w_can_issue) begin
                    w_rd_en  = 1'b1;
                    w_addr_d = r_addr + 1'b1;
                    w_rem_d  = r_rem - 1'b1;
                    if (r_rem == RemOne) begin
                        if (w_src_valid) begin
                            w_take   = 1'b1;
                            w_bank_d = w_src.bank;
                            w_addr_d = '0;
                            w_rem_d  = w_src.len;
                        end else begin
                            w_state_d = StIdle;
                        end
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_bank_busy_d = r_bank_busy;
        if (w_rel_d) begin
            w_bank_busy_d[w_head.bank] = 1'b0;
        end
        if (w_fill_good) begin
            w_bank_busy_d[i_fill_bank] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_alive     <= 1'b0;
            r_q[0]      <= '0;
            r_q[1]      <= '0;
            r_q_wr      <= 1'b0;
            r_q_rd      <= 1'b0;
            r_q_cnt     <= 2'd0;
            r_bank_busy <= 2'b00;
            r_err       <= 1'b0;
            r_state     <= StIdle;
            r_bank      <= 1'b0;
            r_addr      <= '0;
            r_rem       <= '0;
            r_infl      <= 1'b0;
            r_infl_last <= 1'b0;
            r_infl_bank <= 1'b0;
            r_rel       <= 1'b0;
            r_rel_bank  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_q_push) begin
                r_q[r_q_wr] <= w_fill_desc;
                r_q_wr      <= !r_q_wr;
            end
            if (w_q_pop) begin
                r_q_rd <= !r_q_rd;
            end
            case ({w_q_push, w_q_pop})
                2'b10:   r_q_cnt <= r_q_cnt + 2'd1;
                2'b01:   r_q_cnt <= r_q_cnt - 2'd1;
                default: r_q_cnt <= r_q_cnt;
            endcase
            r_bank_busy <= w_bank_busy_d;
            r_err       <= r_err || (w_fill_acc && w_fill_bad);
            r_state     <= w_state_d;
            r_bank      <= w_bank_d;
            r_addr      <= w_addr_d;
            r_rem       <= w_rem_d;
            r_infl      <= w_rd_en;
            r_infl_last <= w_rd_en && (r_rem == RemOne);
            r_infl_bank <= r_bank;
            r_rel       <= w_rel_d;
            r_rel_bank  <= w_head.bank;
        end
    end

    assign w_push_data = '{data: i_ram_rd_data, last: r_infl_last, bank: r_infl_bank};

    dbram_skid_fifo2 u_out_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_infl),
        .i_data  (w_push_data),
        .i_pop   (w_pop_out),
        .o_head  (w_head),
        .o_valid (w_out_valid),
        .o_occ   (w_occ)
    );

    assign o_ram_rd_en    = w_rd_en;
    assign o_ram_rd_sel   = r_bank;
    assign o_ram_rd_addr  = r_addr;
    assign o_m_valid      = w_out_valid;
    assign o_m_data       = w_head.data;
    assign o_m_last       = w_head.last;
    assign o_bank_release = r_rel;
    assign o_release_bank = r_rel_bank;
    assign o_busy         = w_q_nonempty || (r_state == StRead) || r_infl || w_out_valid;
    assign o_err          = r_err;

endmodule

// File: tb/tb_dbram_stream_reader.sv
// Directed bench for dbram_stream_reader: a table of single-bank streams with
// varied m_ready patterns, plus hand sequences for latency, back-to-back banks,
// descriptor errors and reset mid-stream.
module tb_dbram_stream_reader;

    localparam int AW = 11;
    localparam int DW = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    logic          fill_bank = 1'b0;
    logic [AW:0]   fill_len = '0;
    logic          ram_rd_en;
    logic          ram_rd_sel;
    logic [AW-1:0] ram_rd_addr;
    logic [DW-1:0] ram_rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          bank_release;
    logic          release_bank;
    logic          busy;
    logic          err;

    always #5 clk = ~clk;

    dbram_stream_reader dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_fill_valid   (fill_valid),
        .o_fill_ready   (fill_ready),
        .i_fill_bank    (fill_bank),
        .i_fill_len     (fill_len),
        .o_ram_rd_en    (ram_rd_en),
        .o_ram_rd_sel   (ram_rd_sel),
        .o_ram_rd_addr  (ram_rd_addr),
        .i_ram_rd_data  (ram_rd_data),
        .o_m_valid      (m_valid),
        .i_m_ready      (m_ready),
        .o_m_data       (m_data),
        .o_m_last       (m_last),
        .o_bank_release (bank_release),
        .o_release_bank (release_bank),
        .o_busy         (busy),
        .o_err          (err)
    );

    // Content of each RAM word, distinct per bank and address.
    function automatic logic [DW-1:0] ram_word(input logic b, input int a);
        logic [27:0] mid;
        mid = 28'(a * 7 + 53);
        return {b, mid, 11'(a)};
    endfunction

    // RAM model: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= ram_word(ram_rd_sel, int'(ram_rd_addr));
    end

    // Downstream ready pattern, replayed cyclically.
    logic [7:0] rdy_pat = 8'h01;
    int         rdy_len = 1;
    int         rdy_idx = 0;
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = rdy_pat[rdy_idx % rdy_len];
        rdy_idx++;
    end

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } word_t;

    word_t obs_q[$];
    word_t exp_q[$];
    logic  rel_obs[$];
    logic  rel_exp[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic  hold = 1'b0;
    logic [DW-1:0] hold_data = '0;
    int    last_rd_addr = -1;

    // Monitor: records handshakes and release pulses, checks stalled words.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                n_cmp++;
                if (!m_valid || m_data !== hold_data) begin
                    n_bad++;
                    $display("FAIL stall_hold: m_valid=%0b m_data=%h, required m_valid=1 m_data=%h",
                             m_valid, m_data, hold_data);
                end
            end
            hold      = m_valid && !m_ready;
            hold_data = m_data;
            if (m_valid && m_ready) obs_q.push_back('{data: m_data, last: m_last});
            if (bank_release) rel_obs.push_back(release_bank);
            if (ram_rd_en) last_rd_addr = int'(ram_rd_addr);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Offer a descriptor (called just after a rising edge); returns just after
    // the edge on which it was accepted.
    task automatic do_fill(input logic b, input int len);
        int   k;
        logic done;
        k = 0;
        done = 1'b0;
        fill_valid = 1'b1;
        fill_bank  = b;
        fill_len   = 12'(len);
        while (!done && k < 100) begin
            @(negedge clk);
            done = fill_ready;
            k++;
            @(posedge clk);
            #1;
        end
        fill_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL fill_handshake: fill_ready=0 for 100 cycles, required 1");
        end
    endtask

    task automatic expect_stream(input logic b, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back('{data: ram_word(b, i), last: (i == n - 1)});
        rel_exp.push_back(b);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", budget);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_results(input string name);
        int n;
        chk({name, "_word_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", name, i), 64'(obs_q[i].data), 64'(exp_q[i].data));
            chk($sformatf("%s_last%0d", name, i), 64'(obs_q[i].last), 64'(exp_q[i].last));
        end
        chk({name, "_release_count"}, 64'(rel_obs.size()), 64'(rel_exp.size()));
        n = (rel_obs.size() < rel_exp.size()) ? rel_obs.size() : rel_exp.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_release_bank%0d", name, i), 64'(rel_obs[i]), 64'(rel_exp[i]));
        end
        obs_q.delete();
        exp_q.delete();
        rel_obs.delete();
        rel_exp.delete();
    endtask

    typedef struct {
        logic       bank;
        int         len;
        logic [7:0] pat;
        int         plen;
        logic       exp_err;
        int         exp_last_addr;
    } vec_t;

    vec_t vecs [5];

    // Cycle-by-cycle expectations after the len-4 accept edge (k = 1..7).
    int exp_rden [7] = '{1, 1, 1, 1, 0, 0, 0};
    int exp_mv   [7] = '{0, 0, 1, 1, 1, 1, 0};
    int exp_last [7] = '{0, 0, 0, 0, 0, 1, 0};
    int exp_rel  [7] = '{0, 0, 0, 0, 0, 0, 1};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int k;

        vecs[0] = '{bank: 1'b1, len: 1,    pat: 8'h01, plen: 1, exp_err: 1'b0, exp_last_addr: 0};
        vecs[1] = '{bank: 1'b0, len: 8,    pat: 8'h01, plen: 3, exp_err: 1'b0, exp_last_addr: 7};
        vecs[2] = '{bank: 1'b1, len: 5,    pat: 8'h02, plen: 2, exp_err: 1'b0, exp_last_addr: 4};
        vecs[3] = '{bank: 1'b0, len: 2048, pat: 8'h01, plen: 1, exp_err: 1'b0, exp_last_addr: 2047};
        vecs[4] = '{bank: 1'b1, len: 13,   pat: 8'h0D, plen: 4, exp_err: 1'b0, exp_last_addr: 12};

        // Reset state.
        #12;
        chk("rst_fill_ready", 64'(fill_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_rd_en", 64'(ram_rd_en), 64'd0);
        chk("rst_bank_release", 64'(bank_release), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("fill_ready_after_rst", 64'(fill_ready), 64'd1);

        // Single bank, exact cycle timing.
        sync();
        do_fill(1'b0, 4);
        expect_stream(1'b0, 4);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk($sformatf("lat_rd_en%0d", i + 1), 64'(ram_rd_en), 64'(exp_rden[i]));
            if (exp_rden[i] != 0) begin
                chk($sformatf("lat_rd_addr%0d", i + 1), 64'(ram_rd_addr), 64'(i));
                chk($sformatf("lat_rd_sel%0d", i + 1), 64'(ram_rd_sel), 64'd0);
            end
            chk($sformatf("lat_m_valid%0d", i + 1), 64'(m_valid), 64'(exp_mv[i]));
            chk($sformatf("lat_m_last%0d", i + 1), 64'(m_valid && m_last), 64'(exp_last[i]));
            chk($sformatf("lat_release%0d", i + 1), 64'(bank_release), 64'(exp_rel[i]));
        end
        chk("lat_release_bank", 64'(release_bank), 64'd0);
        wait_idle(50);
        check_results("single");

        // Table of single-bank streams under different ready patterns.
        for (int v = 0; v < 5; v++) begin
            rdy_pat = vecs[v].pat;
            rdy_len = vecs[v].plen;
            rdy_idx = 0;
            sync();
            last_rd_addr = -1;
            do_fill(vecs[v].bank, vecs[v].len);
            expect_stream(vecs[v].bank, vecs[v].len);
            wait_idle(vecs[v].len * 4 + 50);
            chk($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].exp_err));
            chk($sformatf("vec%0d_last_addr", v), 64'(last_rd_addr), 64'(vecs[v].exp_last_addr));
            check_results($sformatf("vec%0d", v));
        end

        // Back-to-back banks: no bubble between them.
        rdy_pat = 8'h01;
        rdy_len = 1;
        repeat (2) sync();
        do_fill(1'b0, 3);
        do_fill(1'b1, 2);
        expect_stream(1'b0, 3);
        expect_stream(1'b1, 2);
        k = 0;
        while (!m_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        cnt = 0;
        while (m_valid && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("b2b_contiguous_valid", 64'(cnt), 64'd5);
        wait_idle(50);
        check_results("b2b");

        // Descriptor errors: all three dropped, err sticky.
        sync();
        do_fill(1'b0, 0);
        @(negedge clk);
        chk("err_len0", 64'(err), 64'd1);
        rdy_pat = 8'h00;
        repeat (2) sync();
        do_fill(1'b1, 6);
        expect_stream(1'b1, 6);
        do_fill(1'b1, 4);
        @(negedge clk);
        chk("err_dup_bank", 64'(err), 64'd1);
        sync();
        do_fill(1'b0, 2049);
        repeat (10) @(negedge clk);
        chk("err_len2049", 64'(err), 64'd1);
        chk("err_stalled_no_words", 64'(obs_q.size()), 64'd0);
        rdy_pat = 8'h01;
        wait_idle(100);
        chk("err_still_set", 64'(err), 64'd1);
        check_results("err");

        // Reset in the middle of a 10-word stream.
        sync();
        do_fill(1'b0, 10);
        k = 0;
        while (obs_q.size() < 5 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("mid_words_before_reset", 64'(obs_q.size() >= 5), 64'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_release", 64'(bank_release), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_err", 64'(err), 64'd0);
        chk("mid_rst_fill_ready", 64'(fill_ready), 64'd0);
        chk("mid_no_release", 64'(rel_obs.size()), 64'd0);
        obs_q.delete();
        rel_obs.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_fill_ready_back", 64'(fill_ready), 64'd1);
        sync();
        last_rd_addr = -1;
        do_fill(1'b0, 2);
        expect_stream(1'b0, 2);
        wait_idle(50);
        chk("mid_last_addr", 64'(last_rd_addr), 64'd1);
        check_results("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
